// File: rtl/divider_pkg.sv
// ============================================================================
// divider_pkg : shared types and constants for the restoring-divider control
// Revision    : 1.0
// ============================================================================
`default_nettype none

package divider_pkg;

  localparam int ITER  = 8;
  localparam int CNT_W = 3;

  localparam logic [1:0] SEL_LOAD = 2'b10;
  localparam logic [1:0] SEL_ALU  = 2'b01;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SUB    = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/divider_iter_counter.sv
// ============================================================================
// divider_iter_counter : 3-bit iteration counter with clear, increment, last
// Revision             : 1.0
// ============================================================================
`default_nettype none

module divider_iter_counter
  import divider_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic last_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Increment past ITER-1 wraps naturally to zero.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == CNT_W'(ITER - 1));

endmodule

`default_nettype wire

// File: rtl/divider_control.sv
// ============================================================================
// divider_control : sequencing FSM for the 8-bit by 7-bit restoring divider
//                   Optional macro DIVZERO_DETECT_EN enables divide-by-zero flag
// Revision        : 1.0
// ============================================================================
`default_nettype none

module divider_control
  import divider_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sign,
  input  logic [6:0] divisorin,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       inbit,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_t state_q;
  state_t state_d;
  logic   sign_q;
  logic   sign_d;
  logic   last;
  logic   div_zero;

  divider_iter_counter u_iter_counter (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (state_q == ST_LOAD),
    .inc_i  (state_q == ST_UPDATE),
    .last_o (last)
  );

`ifdef DIVZERO_DETECT_EN
  logic err_q;
  logic err_d;

  assign div_zero = (divisorin == 7'd0);
  // Flag lives only for the DONE cycle reached directly from IDLE.
  assign err_d    = (state_q == ST_IDLE) && start && div_zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_divisorin;

  assign unused_divisorin = ^divisorin;
  assign div_zero         = 1'b0;
  assign err              = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = div_zero ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD:   state_d = ST_SUB;
      ST_SUB: begin
        sign_d  = sign;
        state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = last ? ST_DONE : ST_SUB;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    inbit = 1'b0;
    sel   = SEL_HOLD;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        load  = 1'b1;
        sel   = SEL_LOAD;
        shift = 1'b1;
        busy  = 1'b1;
      end
      ST_SUB: begin
        sel  = SEL_ALU;
        busy = 1'b1;
      end
      ST_UPDATE: begin
        busy  = 1'b1;
        shift = 1'b1;
        // Negative trial difference: add the divisor back, quotient bit 0.
        if (sign_q) begin
          sel = SEL_ALU;
          add = 1'b1;
        end else begin
          sel   = SEL_HOLD;
          inbit = 1'b1;
        end
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_divider_control.sv
// ============================================================================
// tb_divider_control : divider_control with a behavioural divider datapath
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_divider_control;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       sign;
  logic [6:0] divisorin = 7'd0;
  logic [7:0] dividend = 8'd0;
  logic       load, add, shift, inbit, busy, done, err;
  logic [1:0] sel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  divider_control dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .sign      (sign),
    .divisorin (divisorin),
    .load      (load),
    .add       (add),
    .shift     (shift),
    .inbit     (inbit),
    .sel       (sel),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Datapath: divisor register, 16-bit remainder/quotient shift register, adder.
  logic [15:0] rem_q;
  logic [6:0]  dreg_q;
  logic [7:0]  alu;
  logic [15:0] mux;

  always_comb begin
    alu = add ? (rem_q[15:8] + {1'b0, dreg_q}) : (rem_q[15:8] - {1'b0, dreg_q});
    case (sel)
      2'b10:   mux = {8'h00, dividend};
      2'b01:   mux = {alu, rem_q[7:0]};
      default: mux = rem_q;
    endcase
  end
  assign sign = alu[7];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= 16'd0;
      dreg_q <= 7'd0;
    end else begin
      if (load) dreg_q <= divisorin;
      rem_q <= shift ? {mux[14:0], inbit} : mux;
    end
  end

  typedef struct {
    logic [7:0] dvd;
    logic [6:0] dvs;
    int         sp1;
    int         sp2;
    int         exp_cyc;
    logic [7:0] exp_q;
    logic [6:0] exp_r;
    logic       exp_err;
    int         exp_loads;
    int         exp_busy;
    bit         chk_res;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   dcyc = 0;
    int   nload = 0;
    int   nbusy = 0;
    int   nones = 0;
    int   ndone = 0;
    logic errv = 1'b0;
    dividend  = v.dvd;
    divisorin = v.dvs;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (load) nload++;
      if (busy) nbusy++;
      if (inbit) nones++;
      if (done) begin
        ndone++;
        if (dcyc == 0) begin
          dcyc = c;
          errv = err;
        end
      end
      start = (c == v.sp1) || (c == v.sp2);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk({tag, " done_cycle"}, dcyc, v.exp_cyc);
    chk({tag, " done_pulses"}, ndone, 1);
    chk({tag, " err_at_done"}, int'(errv), int'(v.exp_err));
    chk({tag, " load_cycles"}, nload, v.exp_loads);
    chk({tag, " busy_cycles"}, nbusy, v.exp_busy);
    chk({tag, " err_after"}, int'(err), 0);
    if (v.chk_res) begin
      chk({tag, " quotient"}, int'(rem_q[7:0]), int'(v.exp_q));
      chk({tag, " remainder"}, int'(rem_q[15:9]), int'(v.exp_r));
      chk({tag, " ones_shifted"}, nones, $countones(v.exp_q));
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk(name, int'({load, add, shift, inbit, sel, busy, done, err}), 24);
  endtask

  initial begin
    //         dvd     dvs     sp1 sp2 cyc  q      r     err   ld busy res
    vecs[0] = '{8'd100, 7'd7,   -1, -1, 18, 8'd14,  7'd2,  1'b0, 1, 17, 1'b1};
    vecs[1] = '{8'd255, 7'd1,   -1, -1, 18, 8'd255, 7'd0,  1'b0, 1, 17, 1'b1};
    vecs[2] = '{8'd5,   7'd9,   -1, -1, 18, 8'd0,   7'd5,  1'b0, 1, 17, 1'b1};
    vecs[3] = '{8'd200, 7'd127, -1, -1, 18, 8'd1,   7'd73, 1'b0, 1, 17, 1'b1};
    vecs[4] = '{8'd100, 7'd7,    5, 12, 18, 8'd14,  7'd2,  1'b0, 1, 17, 1'b1};
`ifdef DIVZERO_DETECT_EN
    vecs[5] = '{8'd77,  7'd0,   -1, -1,  1, 8'd0,   7'd0,  1'b1, 0, 0,  1'b0};
`else
    vecs[5] = '{8'd77,  7'd0,   -1, -1, 18, 8'd0,   7'd0,  1'b0, 1, 17, 1'b0};
`endif

    repeat (2) @(posedge clk);
    #1 chk_idle_outputs("reset_outputs");
    reset = 1'b1;
    @(posedge clk);
    #1 chk_idle_outputs("idle_after_reset");

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a division, then a clean rerun.
    dividend  = 8'd100;
    divisorin = 7'd7;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("midrun_busy", int'(busy), 1);
    #1 reset = 1'b0;
    #1 chk_idle_outputs("async_reset_outputs");
    @(posedge clk);
    #1 chk_idle_outputs("held_reset_outputs");
    reset = 1'b1;
    @(posedge clk);
    #1 chk_idle_outputs("post_reset_idle");
    run_vec(vecs[0], "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
